mb_pack: RTL

//  Upstream neighbour of the mb serializer. Per coefficient block, takes a BLK-bit significance vector
//  and a BLK-bit sign vector, and extracts the indices of set significance bits in ascending order.

---
 rtl/mb_pkg.sv | 22 ++
 rtl/mb_pack_lsb_find.sv | 21 ++
 rtl/mb_pack.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mb_pkg.sv
// Shared definitions for the mb packer and the mb serializer.
// Block geometry, FSM encoding and the FIFO entry layout.
package mb_pkg;

   localparam int BLK = 64;
   localparam int PW  = $clog2(BLK);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      WRITE = 2'd2
   } mb_state_e;

   typedef struct packed {
      logic [BLK-1:0]    sign;
      logic [BLK*PW-1:0] pos;
      logic [PW:0]       size;
      logic              slice_end;
      logic              no_sign;
   } mb_entry_t;

endpackage

// File: rtl/mb_pack_lsb_find.sv
// Combinational priority encoder: index of the lowest set bit.
// idx is 0 when nothing is set; any qualifies it.
module lsb_find #(
   parameter int BLK = 64,
   parameter int PW  = $clog2(BLK)
) (
   input  logic [BLK-1:0] in_vec,
   output logic [PW-1:0]  idx,
   output logic           any
);

   always_comb begin
      idx = '0;
      for (int i = BLK - 1; i >= 0; i--) begin
         if (in_vec[i]) idx = PW'(i);
      end
   end

   assign any = |in_vec;

endmodule

// File: rtl/mb_pack.sv
// Compacts the set significance bits of a block into a top-aligned
// {sign, pos, size, slice_end, no_sign} entry for the mb FIFO.
module mb_pack
   import mb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BLK-1:0]    sig_in,
   input  logic [BLK-1:0]    sgn_in,
   input  logic              slice_end_in,
   input  logic              mb_full,
   output logic              mb_wr,
   output logic [BLK-1:0]    sign_out,
   output logic [BLK*PW-1:0] pos_out,
   output logic [PW:0]       size_out,
   output logic              slice_end_out,
   output logic              no_sign_out
);

   localparam logic [PW-1:0] SLOT_TOP = PW'(BLK - 1);

   mb_state_e         state_q, state_d;
   logic [BLK-1:0]    rem_q, rem_d;
   logic [BLK-1:0]    sgn_q, sgn_d;
   logic [PW:0]       cnt_q, cnt_d;
   logic [BLK-1:0]    sign_q, sign_d;
   logic [BLK*PW-1:0] pos_q, pos_d;
   logic              slice_end_q, slice_end_d;
   logic              no_sign_q, no_sign_d;

   logic [PW-1:0]     idx;
   logic              any;
   logic [BLK-1:0]    rem_clr;
   logic [PW-1:0]     slot;

   lsb_find #(.BLK(BLK), .PW(PW)) u_lsb (
      .in_vec (rem_q),
      .idx    (idx),
      .any    (any)
   );

   assign rem_clr = rem_q & (rem_q - BLK'(1));
   assign slot    = SLOT_TOP - cnt_q[PW-1:0];

   assign in_ready = clk_en && (state_q == IDLE);
   assign mb_wr    = clk_en && (state_q == WRITE) && !mb_full;

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      sgn_d       = sgn_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      pos_d       = pos_q;
      slice_end_d = slice_end_q;
      no_sign_d   = no_sign_q;
      if (clk_en) begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  rem_d       = sig_in;
                  sgn_d       = sgn_in;
                  slice_end_d = slice_end_in;
                  sign_d      = '0;
                  pos_d       = '0;
                  cnt_d       = '0;
                  state_d     = SCAN;
               end
            end
            SCAN: begin
               if (any) begin
                  for (int s = 0; s < BLK; s++) begin
                     if (slot == PW'(s)) begin
                        pos_d[s*PW +: PW] = idx;
                        sign_d[s]         = sgn_q[idx];
                     end
                  end
                  rem_d = rem_clr;
                  cnt_d = cnt_q + (PW+1)'(1);
               end
               // Covers both the final set bit and an empty block.
               if (rem_clr == '0) begin
                  state_d   = WRITE;
                  no_sign_d = (cnt_d == '0);
               end
            end
            WRITE: begin
               if (!mb_full) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         sgn_q       <= '0;
         cnt_q       <= '0;
         sign_q      <= '0;
         pos_q       <= '0;
         slice_end_q <= 1'b0;
         no_sign_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         sgn_q       <= sgn_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         pos_q       <= pos_d;
         slice_end_q <= slice_end_d;
         no_sign_q   <= no_sign_d;
      end
   end

   assign sign_out      = sign_q;
   assign pos_out       = pos_q;
   assign size_out      = cnt_q;
   assign slice_end_out = slice_end_q;
   assign no_sign_out   = no_sign_q;

endmodule
